// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem: arbiter state encoding,
// the 16-bit word/address type and the default cache-line width.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int DEFAULT_LINE_WIDTH = 128;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first pending port found
// when scanning upward from rr_ptr_i, wrapping back to port 0.
module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pending_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [PTR_W-1:0]     grant_o,
    output logic                 valid_o
);

    int idx;

    // Offsets are scanned in increasing order, so the port closest to the pointer wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!valid_o && pending_i[idx]) begin
                grant_o = PTR_W'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that multiplexes several read/write requesters onto a
// single physical memory port, one transaction at a time.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req_read,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]                  req_resp,
    output logic [LINE_WIDTH-1:0]                 req_rdata,
    output logic                                  pmem_read,
    output logic                                  pmem_write,
    output logic [ADDR_WIDTH-1:0]                 pmem_address,
    output logic [LINE_WIDTH-1:0]                 pmem_wdata,
    input  logic                                  pmem_resp,
    input  logic [LINE_WIDTH-1:0]                 pmem_rdata
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        rrPtr_q, rrPtr_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic                    isWrite_q, isWrite_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

    logic [NUM_PORTS-1:0]    pending;
    logic [PTR_W-1:0]        pickIdx;
    logic                    pickValid;
    logic [PTR_W-1:0]        grantNext;

    assign pending = req_read | req_write;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .pending_i (pending),
        .rr_ptr_i  (rrPtr_q),
        .grant_o   (pickIdx),
        .valid_o   (pickValid)
    );

    assign grantNext = (grant_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    // Memory-side address and data come only from the latched copies, so a
    // requester changing its inputs mid-transaction cannot disturb memory.
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign req_rdata    = pmem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grant_q   <= '0;
            isWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            grant_q   <= grant_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // A port with both read and write raised is treated as a read.
    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        grant_d    = grant_q;
        isWrite_d  = isWrite_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        req_resp   = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    grant_d   = pickIdx;
                    isWrite_d = ~req_read[pickIdx];
                    addr_d    = req_address[pickIdx];
                    wdata_d   = req_wdata[pickIdx];
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                pmem_read  = ~isWrite_q;
                pmem_write = isWrite_q;
                if (pmem_resp) begin
                    req_resp[grant_q] = 1'b1;
                    rrPtr_d           = grantNext;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a queue-free round-robin reference model.
module tb_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    logic                  clk;
    logic                  rst;
    logic [NP-1:0]         reqRead;
    logic [NP-1:0]         reqWrite;
    logic [NP-1:0][AW-1:0] reqAddress;
    logic [NP-1:0][LW-1:0] reqWdata;
    logic [NP-1:0]         reqResp;
    logic [LW-1:0]         reqRdata;
    logic                  pmemRead;
    logic                  pmemWrite;
    logic [AW-1:0]         pmemAddress;
    logic [LW-1:0]         pmemWdata;
    logic                  pmemResp;
    logic [LW-1:0]         pmemRdata;

    int checkCount = 0;
    int passCount  = 0;
    int modelPtr   = 0;

    mem_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_read     (reqRead),
        .req_write    (reqWrite),
        .req_address  (reqAddress),
        .req_wdata    (reqWdata),
        .req_resp     (reqResp),
        .req_rdata    (reqRdata),
        .pmem_read    (pmemRead),
        .pmem_write   (pmemWrite),
        .pmem_address (pmemAddress),
        .pmem_wdata   (pmemWdata),
        .pmem_resp    (pmemResp),
        .pmem_rdata   (pmemRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        reqRead    = '0;
        reqWrite   = '0;
        reqAddress = '0;
        reqWdata   = '0;
        pmemResp   = 1'b0;
        pmemRdata  = '0;
        tick();
        rst      = 1'b0;
        modelPtr = 0;
    endtask

    function automatic logic [LW-1:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic newRequest(input int p);
        int op;
        op = int'($urandom_range(0, 2));
        reqRead[p]    = (op != 1);
        reqWrite[p]   = (op != 0);
        reqAddress[p] = AW'($urandom);
        reqWdata[p]   = randLine();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqRead = 4'b0101; reqWrite = 4'b0010; pmemResp = 1'b1;
        reqAddress = '1; reqWdata = '1; pmemRdata = '0;
        #1;
        checkCount++;
        if ({reqResp, pmemRead, pmemWrite, pmemAddress, pmemWdata} !== '0)
            $display("[TB] FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h expected all zero", reqResp, pmemRead, pmemWrite, pmemAddress);
        else passCount++;
        tick();
        checkCount++;
        if ({reqResp, pmemRead, pmemWrite, pmemAddress} !== '0)
            $display("[TB] FAIL reset_held: got resp=%b rd=%b wr=%b addr=%h expected all zero", reqResp, pmemRead, pmemWrite, pmemAddress);
        else passCount++;
    endtask

    task automatic test_single_read();
        doReset();
        reqRead[0] = 1'b1; reqAddress[0] = 16'h1230;
        #1;
        checkCount++;
        if (pmemRead !== 1'b0) $display("[TB] FAIL read_cycle0: got pmem_read=%b expected 0", pmemRead);
        else passCount++;
        tick();
        checkCount++;
        if ({pmemRead, pmemWrite, pmemAddress} !== {1'b1, 1'b0, 16'h1230})
            $display("[TB] FAIL read_cycle1: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=1230", pmemRead, pmemWrite, pmemAddress);
        else passCount++;
        tick();
        tick();
        pmemResp = 1'b1; pmemRdata = {16{8'hA5}};
        #1;
        checkCount++;
        if ({reqResp, reqRdata} !== {4'b0001, {16{8'hA5}}})
            $display("[TB] FAIL read_resp: got resp=%b rdata=%h expected resp=0001 rdata=a5..a5", reqResp, reqRdata);
        else passCount++;
        tick();
        pmemResp = 1'b0; reqRead[0] = 1'b0;
        #1;
        checkCount++;
        if ({pmemRead, reqResp} !== 5'b0)
            $display("[TB] FAIL read_after: got rd=%b resp=%b expected rd=0 resp=0000", pmemRead, reqResp);
        else passCount++;
    endtask

    task automatic test_alternate();
        int expPort;
        doReset();
        reqRead[0] = 1'b1; reqRead[1] = 1'b1;
        reqAddress[0] = 16'h0100; reqAddress[1] = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            expPort = k % 2;
            tick();
            pmemResp = 1'b1;
            #1;
            checkCount++;
            if (reqResp !== NP'(1 << expPort))
                $display("[TB] FAIL alternate_%0d: got resp=%b expected port %0d", k, reqResp, expPort);
            else passCount++;
            tick();
            pmemResp = 1'b0;
        end
    endtask

    task automatic test_rr_skip();
        doReset();
        reqWrite[1] = 1'b1; reqAddress[1] = 16'h0111;
        tick();
        pmemResp = 1'b1;
        tick();
        pmemResp = 1'b0; reqWrite[1] = 1'b0;
        reqRead[1] = 1'b1; reqAddress[1] = 16'h0101;
        reqRead[3] = 1'b1; reqAddress[3] = 16'h0303;
        tick();
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if ({reqResp, pmemAddress} !== {4'b1000, 16'h0303})
            $display("[TB] FAIL rr_skip_first: got resp=%b addr=%h expected resp=1000 addr=0303", reqResp, pmemAddress);
        else passCount++;
        tick();
        pmemResp = 1'b0; reqRead[3] = 1'b0;
        tick();
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if ({reqResp, pmemAddress} !== {4'b0010, 16'h0101})
            $display("[TB] FAIL rr_skip_second: got resp=%b addr=%h expected resp=0010 addr=0101", reqResp, pmemAddress);
        else passCount++;
        tick();
        pmemResp = 1'b0; reqRead[1] = 1'b0;
    endtask

    task automatic test_addr_hold();
        doReset();
        reqWrite[1] = 1'b1; reqAddress[1] = 16'h0040; reqWdata[1] = {8{16'h1111}};
        tick();
        reqAddress[1] = 16'hBEEF; reqWdata[1] = '0;
        tick();
        #1;
        checkCount++;
        if ({pmemWrite, pmemRead, pmemAddress, pmemWdata} !== {1'b1, 1'b0, 16'h0040, {8{16'h1111}}})
            $display("[TB] FAIL addr_hold: got wr=%b rd=%b addr=%h wdata=%h expected wr=1 rd=0 addr=0040 wdata=1111..", pmemWrite, pmemRead, pmemAddress, pmemWdata);
        else passCount++;
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if ({reqResp, pmemAddress} !== {4'b0010, 16'h0040})
            $display("[TB] FAIL addr_hold_resp: got resp=%b addr=%h expected resp=0010 addr=0040", reqResp, pmemAddress);
        else passCount++;
        tick();
        pmemResp = 1'b0; reqWrite[1] = 1'b0;
        #1;
        checkCount++;
        if (pmemWrite !== 1'b0) $display("[TB] FAIL addr_hold_drop: got wr=%b expected 0", pmemWrite);
        else passCount++;
    endtask

    task automatic test_reset_mid_busy();
        doReset();
        reqRead[0] = 1'b1; reqAddress[0] = 16'h0A0A;
        tick();
        pmemResp = 1'b1;
        tick();
        pmemResp = 1'b0; reqRead[0] = 1'b0;
        reqWrite[1] = 1'b1; reqAddress[1] = 16'h0B0B;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkCount++;
        if ({pmemWrite, reqResp} !== 5'b0)
            $display("[TB] FAIL rst_busy_drop: got wr=%b resp=%b expected wr=0 resp=0000", pmemWrite, reqResp);
        else passCount++;
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if (reqResp !== 4'b0) $display("[TB] FAIL rst_busy_noresp: got resp=%b expected 0000", reqResp);
        else passCount++;
        tick();
        pmemResp = 1'b0; reqRead[0] = 1'b1; reqAddress[0] = 16'h0C0C;
        rst = 1'b0;
        tick();
        #1;
        checkCount++;
        if ({pmemRead, pmemWrite, pmemAddress} !== {1'b1, 1'b0, 16'h0C0C})
            $display("[TB] FAIL rst_busy_regrant: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0c0c", pmemRead, pmemWrite, pmemAddress);
        else passCount++;
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if (reqResp !== 4'b0001) $display("[TB] FAIL rst_busy_port0: got resp=%b expected 0001", reqResp);
        else passCount++;
        tick();
        pmemResp = 1'b0;
    endtask

    task automatic test_drop_mid_busy();
        doReset();
        reqRead[0] = 1'b1; reqAddress[0] = 16'h2222;
        tick();
        reqRead[0] = 1'b0;
        tick();
        #1;
        checkCount++;
        if ({pmemRead, pmemAddress} !== {1'b1, 16'h2222})
            $display("[TB] FAIL drop_busy_held: got rd=%b addr=%h expected rd=1 addr=2222", pmemRead, pmemAddress);
        else passCount++;
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if (reqResp !== 4'b0001) $display("[TB] FAIL drop_busy_resp: got resp=%b expected 0001", reqResp);
        else passCount++;
        tick();
        pmemResp = 1'b0;
        tick();
        checkCount++;
        if ({pmemRead, pmemWrite, reqResp} !== 6'b0)
            $display("[TB] FAIL drop_busy_quiet: got rd=%b wr=%b resp=%b expected all zero", pmemRead, pmemWrite, reqResp);
        else passCount++;
    endtask

    task automatic test_idle_resp();
        doReset();
        pmemResp = 1'b1;
        #1;
        checkCount++;
        if (reqResp !== 4'b0) $display("[TB] FAIL idle_resp: got resp=%b expected 0000", reqResp);
        else passCount++;
        tick();
        pmemResp = 1'b0; reqWrite[2] = 1'b1; reqAddress[2] = 16'h0E0E;
        #1;
        checkCount++;
        if ({pmemRead, pmemWrite} !== 2'b00) $display("[TB] FAIL idle_resp_state: got rd=%b wr=%b expected 00", pmemRead, pmemWrite);
        else passCount++;
        tick();
        checkCount++;
        if ({pmemWrite, pmemAddress} !== {1'b1, 16'h0E0E})
            $display("[TB] FAIL idle_resp_grant: got wr=%b addr=%h expected wr=1 addr=0e0e", pmemWrite, pmemAddress);
        else passCount++;
        pmemResp = 1'b1;
        tick();
        pmemResp = 1'b0; reqWrite[2] = 1'b0;
    endtask

    task automatic test_random();
        int            expPort;
        int            p;
        logic          expWr;
        logic [AW-1:0] expAddr;
        logic [LW-1:0] expData;
        logic [LW-1:0] rdata;
        doReset();
        for (int t = 0; t < 60; t++) begin
            for (int q = 0; q < NP; q++)
                if (!(reqRead[q] || reqWrite[q]) && $urandom_range(0, 1) == 1) newRequest(q);
            if ((reqRead | reqWrite) == '0) newRequest(int'($urandom_range(0, NP - 1)));
            expPort = -1;
            for (int i = 0; i < NP; i++) begin
                p = (modelPtr + i) % NP;
                if (expPort < 0 && (reqRead[p] || reqWrite[p])) expPort = p;
            end
            expWr   = !reqRead[expPort];
            expAddr = reqAddress[expPort];
            expData = reqWdata[expPort];
            #1;
            checkCount++;
            if ({pmemRead, pmemWrite, reqResp} !== 6'b0)
                $display("[TB] FAIL rand_idle_%0d: got rd=%b wr=%b resp=%b expected all zero", t, pmemRead, pmemWrite, reqResp);
            else passCount++;
            tick();
            repeat ($urandom_range(0, 3)) begin
                for (int q = 0; q < NP; q++)
                    if (!(reqRead[q] || reqWrite[q]) && $urandom_range(0, 3) == 0) newRequest(q);
                #1;
                checkCount++;
                if ({pmemRead, pmemWrite, pmemAddress, pmemWdata, reqResp} !== {!expWr, expWr, expAddr, expData, 4'b0})
                    $display("[TB] FAIL rand_busy_%0d: got rd=%b wr=%b addr=%h resp=%b expected rd=%b wr=%b addr=%h port=%0d", t, pmemRead, pmemWrite, pmemAddress, reqResp, !expWr, expWr, expAddr, expPort);
                else passCount++;
                tick();
            end
            rdata     = randLine();
            pmemResp  = 1'b1;
            pmemRdata = rdata;
            #1;
            checkCount++;
            if ({reqResp, reqRdata, pmemRead, pmemWrite, pmemAddress, pmemWdata} !== {NP'(1 << expPort), rdata, !expWr, expWr, expAddr, expData})
                $display("[TB] FAIL rand_resp_%0d: got resp=%b rd=%b wr=%b addr=%h expected port=%0d rd=%b wr=%b addr=%h", t, reqResp, pmemRead, pmemWrite, pmemAddress, expPort, !expWr, expWr, expAddr);
            else passCount++;
            tick();
            pmemResp          = 1'b0;
            reqRead[expPort]  = 1'b0;
            reqWrite[expPort] = 1'b0;
            modelPtr          = (expPort + 1) % NP;
        end
    endtask

    initial begin
        rst        = 1'b1;
        reqRead    = '0;
        reqWrite   = '0;
        reqAddress = '0;
        reqWdata   = '0;
        pmemResp   = 1'b0;
        pmemRdata  = '0;
        test_reset();
        test_single_read();
        test_alternate();
        test_rr_skip();
        test_addr_hold();
        test_reset_mid_busy();
        test_drop_mid_busy();
        test_idle_resp();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
